// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: fetches sprite rows from the asset ROM during hblank
// into a shadow line buffer, swaps it in at end of line, emits per-pixel hits.
//
// Ports:
//   clk, reset (async, active-low)     pixel clock and reset
//   hpos, vpos, line_start             raster position, hblank start pulse
//   spr_en/x/y/charc/dir               packed per-slot sprite attributes
//   rom_charc/direction/index          ROM request (0 outside FETCH)
//   rom_data                           combinational ROM row, bit7 = leftmost, 0 = opaque
//   pixel_on, pixel_id                 registered hit and winning slot (1-cycle latency)
//   busy, overrun                      FSM not idle; sticky missed-commit flag
module sprite_line_renderer #(
    parameter int NUM_SPRITES = 4,
    parameter int ID_W        = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               hpos,
    input  logic [9:0]               vpos,
    input  logic                     line_start,
    input  logic [NUM_SPRITES-1:0]   spr_en,
    input  logic [10*NUM_SPRITES-1:0] spr_x,
    input  logic [10*NUM_SPRITES-1:0] spr_y,
    input  logic [4*NUM_SPRITES-1:0] spr_charc,
    input  logic [2*NUM_SPRITES-1:0] spr_dir,
    output logic [3:0]               rom_charc,
    output logic [1:0]               rom_direction,
    output logic [3:0]               rom_index,
    input  logic [7:0]               rom_data,
    output logic                     pixel_on,
    output logic [ID_W-1:0]          pixel_id,
    output logic                     busy,
    output logic                     overrun
);

    localparam int KW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

    state_t        state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [9:0]    target, target_nx;
    logic [9:0]    new_target;
    logic [9:0]    dy;
    logic [9:0]    fetch_x;
    logic          fetch_valid;
    logic          shadow_we;
    logic          shadow_clr;
    logic          commit;
    logic          set_ovr;

    logic          sh_valid  [NUM_SPRITES];
    logic [7:0]    sh_row    [NUM_SPRITES];
    logic [9:0]    sh_x      [NUM_SPRITES];
    logic          act_valid [NUM_SPRITES];
    logic [7:0]    act_row   [NUM_SPRITES];
    logic [9:0]    act_x     [NUM_SPRITES];

    logic [9:0]    pdx;
    logic          any_hit;
    logic [ID_W-1:0] hit_id;

    // The fetch runs during the blanking of line N for line N+1.
    assign new_target = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;

    // mod-1024 difference lets sprites near y=1023 straddle line 0.
    assign dy          = target - spr_y[10*k +: 10];
    assign fetch_x     = spr_x[10*k +: 10];
    assign fetch_valid = spr_en[k] && (dy < 10'd8);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nx      = state;
        k_nx          = k;
        target_nx     = target;
        rom_charc     = 4'd0;
        rom_direction = 2'd0;
        rom_index     = 4'd0;
        shadow_we     = 1'b0;
        shadow_clr    = 1'b0;
        commit        = 1'b0;
        set_ovr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (line_start) begin
                    state_nx  = FETCH;
                    k_nx      = '0;
                    target_nx = new_target;
                end
            end
            FETCH: begin
                rom_charc     = spr_charc[4*k +: 4];
                rom_direction = spr_dir[2*k +: 2];
                rom_index     = {1'b0, dy[2:0]};
                if (line_start) begin
                    set_ovr    = 1'b1;
                    shadow_clr = 1'b1;
                    k_nx       = '0;
                    target_nx  = new_target;
                end else begin
                    shadow_we = 1'b1;
                    if (k == K_LAST) begin
                        state_nx = READY;
                    end else begin
                        k_nx = k + KW'(1);
                    end
                end
            end
            READY: begin
                if (line_start) begin
                    set_ovr    = 1'b1;
                    shadow_clr = 1'b1;
                    state_nx   = FETCH;
                    k_nx       = '0;
                    target_nx  = new_target;
                end else if (hpos == 10'(H_TOTAL - 1)) begin
                    commit   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            k       <= '0;
            target  <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= state_nx;
            k      <= k_nx;
            target <= target_nx;
            if (set_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_valid[i]  <= 1'b0;
                sh_row[i]    <= 8'hFF;
                sh_x[i]      <= 10'd0;
                act_valid[i] <= 1'b0;
                act_row[i]   <= 8'hFF;
                act_x[i]     <= 10'd0;
            end
        end else begin
            if (shadow_clr) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    sh_valid[i] <= 1'b0;
                    sh_row[i]   <= 8'hFF;
                end
            end else if (shadow_we) begin
                sh_valid[k] <= fetch_valid;
                sh_row[k]   <= fetch_valid ? rom_data : 8'hFF;
                sh_x[k]     <= fetch_x;
            end
            if (commit) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    act_valid[i] <= sh_valid[i];
                    act_row[i]   <= sh_row[i];
                    act_x[i]     <= sh_x[i];
                end
            end
        end
    end

    // Walk slots from highest index down so the lowest hit index wins.
    always_comb begin
        pdx     = 10'd0;
        any_hit = 1'b0;
        hit_id  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            pdx = hpos - act_x[i];
            if (act_valid[i] && (pdx < 10'd8) &&
                !act_row[i][3'd7 - pdx[2:0]]) begin
                any_hit = 1'b1;
                hit_id  = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_on <= 1'b0;
            pixel_id <= '0;
        end else begin
            pixel_on <= (hpos < 10'(H_ACTIVE)) && any_hit;
            pixel_id <= ((hpos < 10'(H_ACTIVE)) && any_hit) ? hit_id : '0;
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Testbench for sprite_line_renderer: raster sweep with a ROM model and a
// pixel scoreboard, plus fixed-value checks on the specified scenarios.
module tb_sprite_line_renderer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos;
    logic        line_start;
    logic [N-1:0]  spr_en;
    logic [10*N-1:0] spr_x, spr_y;
    logic [4*N-1:0]  spr_charc;
    logic [2*N-1:0]  spr_dir;
    logic [3:0]  rom_charc;
    logic [1:0]  rom_direction;
    logic [3:0]  rom_index;
    logic [7:0]  rom_data;
    logic        pixel_on;
    logic [1:0]  pixel_id;
    logic        busy, overrun;

    sprite_line_renderer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .line_start(line_start), .spr_en(spr_en), .spr_x(spr_x),
        .spr_y(spr_y), .spr_charc(spr_charc), .spr_dir(spr_dir),
        .rom_charc(rom_charc), .rom_direction(rom_direction),
        .rom_index(rom_index), .rom_data(rom_data),
        .pixel_on(pixel_on), .pixel_id(pixel_id),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(logic [3:0] c, logic [1:0] d,
                                         logic [3:0] i);
        if (c == 4'd0 && d == 2'd0 && i == 4'd0) return 8'hFF;
        if (c == 4'd0 && d == 2'd0 && i == 4'd1) return 8'b10011001;
        return 8'h3C ^ {c, d, i[1:0]};
    endfunction

    always_comb rom_data = rom_f(rom_charc, rom_direction, rom_index);

    typedef struct packed { logic on; logic [1:0] id; } px_t;

    int checks = 0;
    int errors = 0;
    px_t q[$];

    bit         m_av [N];
    logic [7:0] m_ar [N];
    logic [9:0] m_ax [N];
    bit         m_sv [N];
    logic [7:0] m_sr [N];
    logic [9:0] m_sx [N];
    bit         m_busy;
    bit         m_ovr;
    int         fstart;
    logic [9:0] m_tgt;

    logic       log_on  [800];
    logic [1:0] log_id  [800];
    logic [3:0] log_rom [N];

    task automatic set_slot(input int i, input bit en, input int x,
                            input int y, input int c, input int d);
        spr_en[i]          = en;
        spr_x[10*i +: 10]  = 10'(x);
        spr_y[10*i +: 10]  = 10'(y);
        spr_charc[4*i +: 4] = 4'(c);
        spr_dir[2*i +: 2]  = 2'(d);
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) set_slot(i, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_av[i] = 0; m_ar[i] = 8'hFF; m_ax[i] = 0;
            m_sv[i] = 0; m_sr[i] = 8'hFF; m_sx[i] = 0;
        end
        m_busy = 0;
        m_ovr  = 0;
        fstart = -1000;
        m_tgt  = 0;
        q.delete();
    endtask

    task automatic load_shadow(input logic [9:0] v);
        logic [9:0] dy;
        m_tgt = (v == 10'd524) ? 10'd0 : v + 10'd1;
        for (int i = 0; i < N; i++) begin
            dy = m_tgt - spr_y[10*i +: 10];
            m_sv[i] = spr_en[i] && (dy < 10'd8);
            m_sr[i] = m_sv[i] ? rom_f(spr_charc[4*i +: 4], spr_dir[2*i +: 2],
                                      {1'b0, dy[2:0]}) : 8'hFF;
            m_sx[i] = spr_x[10*i +: 10];
        end
    endtask

    function automatic px_t exp_px(logic [9:0] h);
        px_t p;
        logic [9:0] dx;
        p = '0;
        if (h >= 10'd640) return p;
        for (int i = 0; i < N; i++) begin
            dx = h - m_ax[i];
            if (!p.on && m_av[i] && dx < 10'd8 && m_ar[i][7 - dx] == 1'b0) begin
                p.on = 1'b1;
                p.id = 2'(i);
            end
        end
        return p;
    endfunction

    // One raster line; optional second line_start at ls2 with vpos v2;
    // returns just after driving hpos==stop_h when stop_h < 800.
    task automatic run_line(input logic [9:0] v, input int ls2,
                            input logic [9:0] v2, input int stop_h);
        px_t e;
        logic [9:0] dy;
        int kk;
        for (int h = 0; h < 800; h++) begin
            hpos = 10'(h);
            vpos = (ls2 >= 0 && h >= ls2) ? v2 : v;
            line_start = (h == 640) || (h == ls2);
            if (h == stop_h) return;
            #1;
            checks++;
            if (busy !== m_busy)
                $display("FAIL busy h=%0d got %b want %b", h, busy, m_busy);
            if (busy !== m_busy) errors++;
            checks++;
            if (overrun !== m_ovr) begin
                errors++;
                $display("FAIL overrun h=%0d got %b want %b", h, overrun, m_ovr);
            end
            if (m_busy && h >= fstart && h < fstart + N) begin
                kk = h - fstart;
                dy = m_tgt - spr_y[10*kk +: 10];
                log_rom[kk] = rom_index;
                checks++;
                if (rom_index !== {1'b0, dy[2:0]} ||
                    rom_charc !== spr_charc[4*kk +: 4] ||
                    rom_direction !== spr_dir[2*kk +: 2]) begin
                    errors++;
                    $display("FAIL rom_req h=%0d got %h/%h/%h want %h/%h/%h",
                             h, rom_charc, rom_direction, rom_index,
                             spr_charc[4*kk +: 4], spr_dir[2*kk +: 2],
                             {1'b0, dy[2:0]});
                end
            end else begin
                checks++;
                if ({rom_charc, rom_direction, rom_index} !== 10'd0) begin
                    errors++;
                    $display("FAIL rom_idle h=%0d got %h/%h/%h want 0",
                             h, rom_charc, rom_direction, rom_index);
                end
            end
            q.push_back(exp_px(10'(h)));
            @(posedge clk);
            #1;
            if (line_start) begin
                if (m_busy) m_ovr = 1;
                m_busy = 1;
                fstart = h + 1;
                load_shadow(vpos);
            end else if (m_busy && h == 799 && h >= fstart + N) begin
                for (int i = 0; i < N; i++) begin
                    m_av[i] = m_sv[i]; m_ar[i] = m_sr[i]; m_ax[i] = m_sx[i];
                end
                m_busy = 0;
            end
            e = q.pop_front();
            log_on[h] = pixel_on;
            log_id[h] = pixel_id;
            checks++;
            if (pixel_on !== e.on || pixel_id !== e.id) begin
                errors++;
                $display("FAIL pixel h=%0d v=%0d got %b/%0d want %b/%0d",
                         h, v, pixel_on, pixel_id, e.on, e.id);
            end
        end
        line_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        hpos = 0; vpos = 0; line_start = 0;
        clear_slots();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pixel_on, pixel_id, busy, overrun, rom_charc, rom_direction,
             rom_index} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b%b %h/%h/%h want all 0",
                     pixel_on, pixel_id, busy, overrun, rom_charc,
                     rom_direction, rom_index);
        end
        reset = 1'b1;
    endtask

    task automatic test_first_fetch();
        clear_slots();
        set_slot(0, 1, 100, 50, 0, 0);
        run_line(49, -1, 0, 800);
        checks++;
        if (log_rom[0] !== 4'd0) begin
            errors++;
            $display("FAIL first_fetch_index got %0d want 0", log_rom[0]);
        end
        run_line(50, -1, 0, 800);
        checks++;
        if (log_on[102] !== 1'b0) begin
            errors++;
            $display("FAIL row0_blank got %b want 0", log_on[102]);
        end
    endtask

    task automatic test_row();
        logic [8:0] want;
        want = 9'b011001100;
        clear_slots();
        set_slot(0, 1, 100, 49, 0, 0);
        run_line(49, -1, 0, 800);
        run_line(50, -1, 0, 800);
        for (int h = 100; h <= 108; h++) begin
            checks++;
            if (log_on[h] !== want[8 - (h - 100)]) begin
                errors++;
                $display("FAIL row1_pixel h=%0d got %b want %b",
                         h, log_on[h], want[8 - (h - 100)]);
            end
        end
    endtask

    task automatic test_priority();
        clear_slots();
        set_slot(0, 1, 200, 49, 0, 0);
        set_slot(2, 1, 200, 49, 0, 0);
        run_line(49, -1, 0, 800);
        run_line(50, -1, 0, 800);
        checks++;
        if (log_on[201] !== 1'b1 || log_id[201] !== 2'd0) begin
            errors++;
            $display("FAIL prio_both got %b/%0d want 1/0", log_on[201], log_id[201]);
        end
        set_slot(0, 0, 200, 49, 0, 0);
        run_line(49, -1, 0, 800);
        run_line(50, -1, 0, 800);
        checks++;
        if (log_on[201] !== 1'b1 || log_id[201] !== 2'd2) begin
            errors++;
            $display("FAIL prio_slot2 got %b/%0d want 1/2", log_on[201], log_id[201]);
        end
    endtask

    task automatic test_overrun();
        clear_slots();
        set_slot(0, 1, 300, 49, 0, 0);
        run_line(49, 700, 48, 800);
        checks++;
        if (overrun !== 1'b1 || log_rom[0] !== 4'd0) begin
            errors++;
            $display("FAIL overrun_restart got %b/%0d want 1/0", overrun, log_rom[0]);
        end
        run_line(50, -1, 0, 800);
        checks++;
        if (overrun !== 1'b1 || log_on[301] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky got %b/%b want 1/0", overrun, log_on[301]);
        end
    endtask

    task automatic test_wrap();
        clear_slots();
        set_slot(1, 1, 636, 1020, 0, 1);
        run_line(524, -1, 0, 800);
        checks++;
        if (log_rom[1] !== 4'd4) begin
            errors++;
            $display("FAIL wrap_index got %0d want 4", log_rom[1]);
        end
        run_line(0, -1, 0, 800);
        checks++;
        if (log_on[636] !== 1'b1 || log_on[637] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_visible got %b%b want 11", log_on[636], log_on[637]);
        end
        for (int h = 640; h <= 643; h++) begin
            checks++;
            if (log_on[h] !== 1'b0) begin
                errors++;
                $display("FAIL right_clip h=%0d got %b want 0", h, log_on[h]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < N; i++)
                set_slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 660),
                         $urandom_range(95, 103), $urandom_range(0, 15),
                         $urandom_range(0, 3));
            run_line(10'(100 + l), -1, 0, 800);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int seen;
        clear_slots();
        set_slot(0, 1, 100, 49, 0, 0);
        run_line(49, -1, 0, 800);
        run_line(49, -1, 0, 643);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got %b want 1", busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({pixel_on, pixel_id, busy, overrun, rom_charc, rom_direction,
             rom_index} !== 15'd0) begin
            errors++;
            $display("FAIL mid_fetch_reset got %b%b%b%b %h/%h/%h want all 0",
                     pixel_on, pixel_id, busy, overrun, rom_charc,
                     rom_direction, rom_index);
        end
        model_reset();
        line_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_line(50, -1, 0, 800);
        seen = 0;
        for (int h = 0; h < 640; h++) if (log_on[h] === 1'b1) seen++;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL post_reset_line got %0d pixels want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_row();
        test_priority();
        test_overrun();
        test_wrap();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
